data_mem_responder: RTL
=======================

# data_mem_responder

Memory-side responder for the processor's data port. It accepts load/store requests over a req/ready handshake, inserts a programmable number of wait states, commits stores, and returns load data. Misaligned or out-of-range accesses are rejected with an error flag. It replaces the zero-latency data memory so that the processor core, and later a multi-cycle core, can be exercised against realistic memory timing.

## Interface
- ADDR_WIDTH, 10, log2 of the number of 32-bit words stored (1024 words)
- LATENCY, 2, wait-state cycles between request acceptance and response; legal range 0..15
- clk  input  1  single clock; all state updates on posedge
- rst  input  1  asynchronous, active-low reset; rst=0 forces reset state immediately
- req  input  1  request valid; held high with address/we/writeData stable until ready
- we  input  1  1 = store (sw), 0 = load (lw)
- address  input  32  byte address from the ALU result
- writeData  input  32  store data (rt value)
- readData  output  32  load data; valid while ready=1, held until the next response
- ready  output  1  one-cycle response strobe
- err  output  1  qualifies ready: access rejected, no memory effect
- busy  output  1  high from acceptance until the cycle ready is asserted, inclusive

## Operation
- Storage: array of 2^ADDR_WIDTH × 32-bit words. Contents are not cleared by reset and are undefined until written.
- Word index = address[ADDR_WIDTH+1:2].
- Error: address[1:0]≠0, or any of address[31:ADDR_WIDTH+2]≠0. An erroring access performs no read and no write. It completes with readData=0 and err=1, with the same latency as a good access.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if req=1 at a posedge, latch address/we/writeData/error into request registers. Go to WAIT with wait counter=LATENCY-1. If LATENCY=0, go directly to RESP.
  - WAIT: decrement the 4-bit counter each cycle. When the counter=0, go to RESP.
  - RESP: ready=1 for exactly one cycle, err per the latched error. Next state is IDLE.
- Memory effect happens on the posedge entering RESP:
  - good store writes the latched writeData to the word;
  - good load registers the word into readData.
- Stores return readData=0.
- Inputs are sampled only in IDLE. Changes to req/address/data during WAIT/RESP are ignored, and the latched transaction always completes.
- Back-to-back: a request is accepted in the IDLE cycle after RESP if req=1. The minimum issue interval is LATENCY+2 cycles.
- A load following a store to the same word returns the stored value.

## Timing
- Reset values: ready=0, err=0, busy=0, readData=0, state=IDLE, counter=0, request registers=0.
- Latency: acceptance edge t. ready is high in the cycle following edge t+LATENCY. With LATENCY=2, ready is in the 3rd cycle after acceptance.
- busy is combinational from state: 1 in WAIT and RESP, 0 in IDLE.
- ready/err/readData are registered outputs with no combinational path from req or address.
- Reset mid-transaction (rst low at any point before the RESP edge): the transaction is aborted, the pending store is not committed, and no ready is produced. After release the block is in IDLE.
- Reset asserted in the RESP cycle: ready drops immediately. A store already committed at the RESP edge remains in memory.
- req held high continuously: the block repeats the same transaction each IDLE cycle. Dropping req after ready is the initiator's responsibility.
- Counter width is 4 bits. LATENCY>15 is illegal and need not be supported.

## Test plan
- Reset: hold rst=0 for 3 cycles with req=1 → ready=0, err=0, busy=0, readData=0 throughout. No acceptance until rst=1.
- Store/load, LATENCY=2: sw address 0x10 data 0xDEADBEEF, then lw 0x10 → each ready arrives exactly 3 cycles after acceptance, err=0; load readData=0xDEADBEEF; store readData=0.
- Errors:
  - lw address 0x12 (misaligned) → err=1, readData=0, same latency.
  - sw to 0x00001000 (ADDR_WIDTH=10, out of range) → err=1, and word 0 is unchanged on a later read.
- Input churn: accept sw 0x20 data 0x1234, then change address/data/req during WAIT → 0x20 holds 0x1234. No second ready until the next IDLE acceptance.
- Reset mid-op: accept sw 0x40 data 0xAAAA5555 over prior content 0x0, pulse rst low during WAIT → no ready, and a later lw 0x40 returns 0x0.
- LATENCY=0 back-to-back: req held with alternating lw addresses 0x0 and 0x4 → ready every 2nd cycle, data matches prior writes, busy toggles accordingly.

Source files
------------

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data-port memory responder with programmable wait states
module data_mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        ready,
    output logic        err,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    we_q, we_d;
    logic                    bad_q, bad_d;
    logic                    ready_q, ready_d;
    logic                    err_q, err_d;
    logic [31:0]             rdata_q, rdata_d;

    logic [31:0]             mem [2**ADDR_WIDTH];

    logic                    in_bad;
    logic [ADDR_WIDTH-1:0]   t_idx;
    logic [31:0]             t_wdata;
    logic                    t_we;
    logic                    t_bad;
    logic                    enter_resp;
    logic                    mem_we;

    assign in_bad = (address[1:0] != 2'b00) || ((address >> (ADDR_WIDTH + 2)) != 32'd0);

    // With zero wait states the response edge is the acceptance edge, so the
    // transaction is taken straight from the inputs instead of the latches.
    assign t_idx   = (state_q == IDLE) ? address[ADDR_WIDTH+1:2] : idx_q;
    assign t_wdata = (state_q == IDLE) ? writeData : wdata_q;
    assign t_we    = (state_q == IDLE) ? we : we_q;
    assign t_bad   = (state_q == IDLE) ? in_bad : bad_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        bad_d      = bad_q;
        ready_d    = 1'b0;
        err_d      = 1'b0;
        rdata_d    = rdata_q;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    idx_d   = address[ADDR_WIDTH+1:2];
                    wdata_d = writeData;
                    we_d    = we;
                    bad_d   = in_bad;
                    if (LATENCY == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (enter_resp) begin
            ready_d = 1'b1;
            err_d   = t_bad;
            rdata_d = (!t_bad && !t_we) ? mem[t_idx] : 32'd0;
        end
    end

    assign mem_we = enter_resp && t_we && !t_bad;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
            bad_q   <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            bad_q   <= bad_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage is never cleared; the rst term keeps a held reset from committing a store.
    always_ff @(posedge clk) begin
        if (mem_we && rst) begin
            mem[t_idx] <= t_wdata;
        end
    end

    assign readData = rdata_q;
    assign ready    = ready_q;
    assign err      = err_q;
    assign busy     = (state_q != IDLE);
endmodule
